// File: rtl/spi_master.sv
// SPI initiator: full-duplex WIDTH-bit transfers, MSB first.
// All four CPOL/CPHA modes and a programmable spi_clk divider.
module spi_master #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 start,
  input  logic [WIDTH-1:0]     bus_in,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 spi_clk_polarity,
  input  logic                 spi_clk_phase,
  input  logic                 spi_in,
  output logic                 spi_out,
  output logic                 spi_clk,
  output logic                 spi_ss,
  output logic [WIDTH-1:0]     bus_out,
  output logic                 busy,
  output logic                 tx,
  output logic                 rx
);

  localparam int EW = $clog2(2*WIDTH+1);
  localparam logic [EW-1:0] LAST  = EW'(2*WIDTH);
  localparam logic [EW-1:0] FIRST = EW'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]           state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 pol_q;
  logic                 pha_q;
  logic [EW-1:0]        edge_q;
  logic [WIDTH-1:0]     sh;
  logic [WIDTH-1:0]     rcv;
  logic                 tx_q;
  logic                 rx_q;

  logic          tick;
  logic [EW-1:0] nxt;
  logic          lead;
  logic          samp;
  logic          drive;
  logic          last_edge;

  // Half-period timing and per-edge role of the upcoming edge.
  always_comb begin
    tick      = (cnt == div_q);
    nxt       = edge_q + EW'(1);
    lead      = nxt[0];
    samp      = lead ^ pha_q;
    drive     = !samp;
    if (pha_q && nxt == FIRST)
      drive = 1'b0;
    if (!pha_q && nxt == LAST)
      drive = 1'b0;
    last_edge = (state == SHIFT) &&
                (edge_q == LAST);
  end

  assign tx = tx_q & ena;
  assign rx = rx_q & ena;

  // Transfer sequencer: IDLE, SETUP, SHIFT, HOLD, GAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= '0;
      pol_q   <= 1'b0;
      pha_q   <= 1'b0;
      edge_q  <= '0;
      sh      <= '0;
      rcv     <= '0;
      tx_q    <= 1'b0;
      rx_q    <= 1'b0;
      spi_out <= 1'b0;
      spi_clk <= 1'b0;
      spi_ss  <= 1'b1;
      bus_out <= '0;
      busy    <= 1'b0;
    end else if (!ena) begin
      tx_q <= 1'b0;
      rx_q <= 1'b0;
    end else begin
      tx_q <= 1'b0;
      rx_q <= 1'b0;
      case (state)
        IDLE: begin
          spi_clk <= spi_clk_polarity;
          spi_ss  <= 1'b1;
          if (start) begin
            state   <= SETUP;
            busy    <= 1'b1;
            spi_ss  <= 1'b0;
            tx_q    <= 1'b1;
            sh      <= bus_in;
            spi_out <= bus_in[WIDTH-1];
            div_q   <= clk_div;
            pol_q   <= spi_clk_polarity;
            pha_q   <= spi_clk_phase;
            cnt     <= '0;
            edge_q  <= '0;
            rcv     <= '0;
          end
        end
        SETUP, SHIFT: begin
          if (!tick) begin
            cnt <= cnt + DIV_WIDTH'(1);
          end else begin
            cnt <= '0;
            if (last_edge) begin
              state <= HOLD;
            end else begin
              state   <= SHIFT;
              spi_clk <= ~spi_clk;
              edge_q  <= nxt;
              if (samp)
                rcv <= {rcv[WIDTH-2:0], spi_in};
              if (drive) begin
                sh      <= {sh[WIDTH-2:0], 1'b0};
                spi_out <= sh[WIDTH-2];
              end
            end
          end
        end
        HOLD: begin
          if (!tick) begin
            cnt <= cnt + DIV_WIDTH'(1);
          end else begin
            cnt     <= '0;
            state   <= GAP;
            spi_ss  <= 1'b1;
            rx_q    <= 1'b1;
            bus_out <= rcv;
          end
        end
        GAP: begin
          spi_clk <= pol_q;
          if (!tick) begin
            cnt <= cnt + DIV_WIDTH'(1);
          end else begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master against a timing/data
// model derived from the transfer rules and a behavioural slave.
module tb_spi_master;

  localparam int W  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  bus_in = '0;
  logic [DW-1:0] clk_div = '0;
  logic          pol = 1'b0;
  logic          pha = 1'b0;
  logic          spi_in;
  logic          spi_out;
  logic          spi_clk;
  logic          spi_ss;
  logic [W-1:0]  bus_out;
  logic          busy;
  logic          tx;
  logic          rx;

  int checks = 0;
  int errors = 0;

  // MISO source: 0 loopback, 1 tied high, 2 counter slave.
  int           src = 0;
  logic [W-1:0] s_word = '0;
  logic [W-1:0] s_ctr = '0;
  logic         s_pha = 1'b0;
  int           s_idx = 0;
  int           s_edges = 0;

  spi_master #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .start(start),
    .bus_in(bus_in),
    .clk_div(clk_div),
    .spi_clk_polarity(pol),
    .spi_clk_phase(pha),
    .spi_in(spi_in),
    .spi_out(spi_out),
    .spi_clk(spi_clk),
    .spi_ss(spi_ss),
    .bus_out(bus_out),
    .busy(busy),
    .tx(tx),
    .rx(rx)
  );

  always #5 clk = ~clk;

  assign spi_in = (src == 0) ? spi_out :
                  (src == 1) ? 1'b1 :
                  (s_idx >= 0) ? s_word[s_idx] : 1'b0;

  always @(negedge spi_ss) begin
    s_word  = s_ctr;
    s_ctr   = s_ctr + 1'b1;
    s_idx   = W - 1;
    s_edges = 0;
  end

  always @(spi_clk) begin
    if (spi_ss === 1'b0) begin
      s_edges++;
      if (s_pha ? (s_edges % 2 == 1 && s_edges > 1)
                : (s_edges % 2 == 0))
        s_idx--;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input string tag,
                      input logic p_pol,
                      input logic p_pha,
                      input logic [DW-1:0] d,
                      input logic [W-1:0] w,
                      input int s,
                      input int frz_at,
                      input int mid_start);
    int h;
    int frz;
    int budget;
    int tx_k;
    int tx_n;
    int e_first;
    int e_n;
    int e_frz;
    int rx_k;
    int rx_n;
    int done_k;
    logic prev_clk;
    logic prev_ena;
    logic [W-1:0] rise;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_rise;
    h = int'(d) + 1;
    frz = (frz_at > 0) ? 10 : 0;
    tx_k = -1; tx_n = 0;
    e_first = -1; e_n = 0; e_frz = 0;
    rx_k = -1; rx_n = 0; done_k = -1;
    rise = '0;
    pol = p_pol; pha = p_pha; s_pha = p_pha;
    clk_div = d; bus_in = w; src = s; ena = 1'b1;
    repeat (3) tick();
    chk({tag, " idle_clk"}, spi_clk, p_pol);
    chk({tag, " idle_ss"}, spi_ss, 1);
    start = 1'b1;
    prev_clk = spi_clk;
    prev_ena = 1'b1;
    budget = 1 + 19*h + frz + 20;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (tx) begin
        tx_n++;
        if (tx_k < 0) tx_k = k;
      end
      if (rx) begin
        rx_n++;
        if (rx_k < 0) rx_k = k;
      end
      if (busy && spi_clk !== prev_clk) begin
        e_n++;
        if (e_first < 0) e_first = k;
        if (!prev_ena) e_frz++;
        if (spi_clk) rise = {rise[W-2:0], spi_out};
      end
      prev_clk = spi_clk;
      if (k > 1 && !busy) begin
        done_k = k;
        break;
      end
      if (k == 1) begin
        start = 1'b0;
        bus_in = ~w;
        clk_div = DW'($urandom);
        pol = ~p_pol;
        pha = ~p_pha;
      end
      if (mid_start > 0 && k == mid_start) start = 1'b1;
      if (mid_start > 0 && k == mid_start + 1) start = 1'b0;
      if (frz > 0 && k == frz_at) ena = 1'b0;
      if (frz > 0 && k == frz_at + frz) ena = 1'b1;
      prev_ena = ena;
    end
    start = 1'b0;
    ena = 1'b1;
    if (done_k < 0)
      chk({tag, " timeout"}, 0, 1);
    exp_rx = (s == 0) ? w : (s == 1) ? '1 : s_word;
    exp_rise = (p_pol && !p_pha) ? {w[W-2:0], w[0]} : w;
    chk({tag, " tx_at"}, tx_k, 1);
    chk({tag, " tx_n"}, tx_n, 1);
    chk({tag, " edge1"}, e_first, 1 + h);
    chk({tag, " edges"}, e_n, 2*W);
    chk({tag, " frz_edges"}, e_frz, 0);
    chk({tag, " rx_at"}, rx_k, 1 + 18*h + frz);
    chk({tag, " rx_n"}, rx_n, 1);
    chk({tag, " done_at"}, done_k, 1 + 19*h + frz);
    chk({tag, " bus_out"}, bus_out, exp_rx);
    chk({tag, " mosi"}, rise, exp_rise);
    pol = p_pol; pha = p_pha; clk_div = d;
  endtask

  task automatic b2b();
    int h;
    int t1;
    int t2;
    int gapn;
    int fin;
    h = 3;
    t1 = -1; t2 = -1; gapn = 0; fin = -1;
    pol = 1'b0; pha = 1'b0; s_pha = 1'b0;
    clk_div = DW'(h - 1); bus_in = 8'h5A; src = 0;
    repeat (3) tick();
    start = 1'b1;
    for (int k = 1; k <= 2*(1 + 19*h) + 20; k++) begin
      tick();
      if (tx) begin
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
      if (t1 > 0 && t2 < 0 && spi_ss && busy) gapn++;
      if (t2 > 0) start = 1'b0;
      if (t2 > 0 && k > t2 && !busy) begin
        fin = k;
        break;
      end
    end
    start = 1'b0;
    chk("b2b tx1", t1, 1);
    chk("b2b tx2", t2, 2 + 19*h);
    chk("b2b gap", gapn, h);
    chk("b2b fin", fin, t2 + 19*h);
    chk("b2b bus_out", bus_out, 8'h5A);
  endtask

  initial begin
    s_ctr = W'($urandom);
    #1 rst = 1'b0;
    #12;
    chk("rst ss", spi_ss, 1);
    chk("rst clk", spi_clk, 0);
    chk("rst out", spi_out, 0);
    chk("rst busy", busy, 0);
    chk("rst tx", tx, 0);
    chk("rst rx", rx, 0);
    chk("rst bus_out", bus_out, 0);
    #10 rst = 1'b1;
    tick();

    xfer("m0", 1'b0, 1'b0, 8'd4, 8'hA5, 0, 0, 0);
    xfer("m3", 1'b1, 1'b1, 8'd0, 8'h3C, 1, 0, 0);
    xfer("m1", 1'b0, 1'b1, 8'd3, 8'h81, 0, 0, 0);
    xfer("m2", 1'b1, 1'b0, 8'd2, 8'h7E, 0, 0, 0);
    xfer("mid", 1'b0, 1'b0, 8'd1, 8'h5C, 0, 0, 15);
    xfer("frz", 1'b0, 1'b0, 8'd4, 8'hA5, 0, 40, 0);
    xfer("dmax", 1'b0, 1'b1, 8'hFF, 8'h96, 0, 0, 0);
    b2b();

    for (int i = 0; i < 12; i++) begin
      logic [DW-1:0] d;
      int fa;
      int ms;
      d = DW'($urandom_range(0, 5));
      fa = (i % 2 == 1) ?
           int'(d) + 3 + $urandom_range(0, 10*(int'(d) + 1)) : 0;
      ms = (i % 3 == 0) ? $urandom_range(2, 10) : 0;
      xfer("rnd", 1'($urandom), 1'($urandom), d,
           W'($urandom), $urandom_range(0, 2), fa, ms);
    end

    xfer("pre_rst", 1'b0, 1'b0, 8'd4, 8'hC3, 0, 0, 0);
    pol = 1'b0; pha = 1'b0; s_pha = 1'b0;
    clk_div = 8'd4; bus_in = W'($urandom); src = 2;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    #3 rst = 1'b0;
    #1;
    chk("arst ss", spi_ss, 1);
    chk("arst busy", busy, 0);
    chk("arst clk", spi_clk, 0);
    chk("arst bus_out", bus_out, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    tick();
    chk("arst idle", busy, 0);
    xfer("rst_next", 1'b0, 1'b0, 8'd4, W'($urandom), 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
